// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the single-clock and dual-clock FIFOs.
//   fifo_cnt_w(depth)   : bits needed to count 0..depth words
//   fifo_ptr_w(entries) : bits needed to address an array of 'entries' words
//   fifo_status_t       : status bundle {level, free, almost_full, almost_empty}
//                         sized for the widest FIFO in the datapath so both FIFO
//                         flavours can share one status port type.
package fifo_pkg;

  localparam int unsigned FIFO_STATUS_CW = 16;

  typedef struct packed {
    logic [FIFO_STATUS_CW-1:0] level;
    logic [FIFO_STATUS_CW-1:0] free;
    logic                      almost_full;
    logic                      almost_empty;
  } fifo_status_t;

  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned fifo_ptr_w(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: ENTRIES x WIDTH register array backing the single-clock FIFO.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address (0..ENTRIES-1)
//   wdata_i : write data
//   raddr_i : read address (0..ENTRIES-1)
//   rdata_o : asynchronous read data at raddr_i
// Contents are not reset; the FIFO never presents a word it has not written.
module fifo_sync_ram #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ENTRIES = 11,
  parameter int unsigned AW      = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_fwft.sv
// fifo_sync_fwft: single-clock first-word-fall-through FIFO, valid/ready on both
// sides, arbitrary depth (output register counts toward DEPTH).
//   clk          : clock, rising edge
//   resetn       : asynchronous active-low reset
//   flush        : synchronous discard of all contents (highest priority)
//   in_valid     : producer has a word        in_ready  : FIFO accepts this cycle
//   in_data      : write data
//   out_valid    : out_data holds head word   out_ready : consumer takes head
//   out_data     : head word, straight from a flop
//   level / free : words held / DEPTH - level
//   almost_full  : level >= AF_LEVEL          almost_empty : level <= AE_LEVEL
module fifo_sync_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 12,
  parameter int unsigned ABITS    = fifo_cnt_w(DEPTH),
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [ABITS-1:0] level,
  output logic [ABITS-1:0] free,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam logic [ABITS-1:0] DEPTH_L = ABITS'(DEPTH);

  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [ABITS-1:0] level_q, level_d;

  logic             wr_fire;
  logic             rd_fire;
  logic             head_load;
  logic             arr_empty;
  logic             arr_pop;
  logic             bypass;
  logic             arr_we;
  logic [WIDTH-1:0] arr_rdata;

  // Ready depends only on registered level and flush, so a full FIFO never
  // accepts a word on the strength of a concurrent read.
  assign in_ready  = (level_q != DEPTH_L) & ~flush;
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = head_valid_q & out_ready;

  // The head refills whenever it is empty or being consumed. An empty head
  // implies an empty array, so the array holds exactly level - head_valid words.
  assign head_load = ~head_valid_q | rd_fire;
  assign arr_empty = (level_q == ABITS'(head_valid_q));
  assign arr_pop   = head_load & ~arr_empty & ~flush;
  assign bypass    = head_load & arr_empty & wr_fire;
  assign arr_we    = wr_fire & ~bypass;

  always_comb begin
    head_d       = head_q;
    head_valid_d = head_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
    end else if (head_load) begin
      if (!arr_empty) begin
        head_d       = arr_rdata;
        head_valid_d = 1'b1;
      end else if (wr_fire) begin
        head_d       = in_data;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_valid_q <= 1'b0;
      head_q       <= '0;
      level_q      <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
      level_q      <= level_d;
    end
  end

  generate
    if (DEPTH > 2) begin : g_ram
      localparam int unsigned ENTRIES = DEPTH - 1;
      localparam int unsigned PW      = fifo_ptr_w(ENTRIES);
      localparam logic [PW-1:0] LAST  = PW'(ENTRIES - 1);

      logic [PW-1:0] wr_ptr_q, wr_ptr_d;
      logic [PW-1:0] rd_ptr_q, rd_ptr_d;

      // Wrap by explicit compare: ENTRIES need not be a power of two.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else begin
          if (arr_we) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
          end
          if (arr_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
        end
      end

      fifo_sync_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES),
        .AW      (PW)
      ) u_ram (
        .clk_i   (clk),
        .we_i    (arr_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (arr_rdata)
      );
    end else begin : g_skid
      // One array slot: a skid register, no pointers. arr_pop needs no action
      // because a stale skid word is never read while the array is empty.
      logic [WIDTH-1:0] skid_q;
      logic             skid_pop_unused;

      assign skid_pop_unused = arr_pop;

      always_ff @(posedge clk) begin
        if (arr_we) begin
          skid_q <= in_data;
        end
      end

      assign arr_rdata = skid_q;
    end
  endgenerate

  assign out_valid    = head_valid_q;
  assign out_data     = head_q;
  assign level        = level_q;
  assign free         = DEPTH_L - level_q;
  assign almost_full  = (32'(level_q) >= AF_LEVEL);
  assign almost_empty = (32'(level_q) <= AE_LEVEL);

endmodule
